// File: rtl/mem_access_stage.sv
// Memory access stage: drives data-memory loads/stores over a req/ready bus,
// formats load data for mem_wb, stalls the pipeline and reports faults/timeouts.
module mem_access_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter bit          TIMEOUT_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_mem_valid,
    input  logic        ex_mem_memread,
    input  logic        ex_mem_memwrite,
    input  logic [2:0]  ex_mem_funct3,
    input  logic [31:0] result_ex_mem,
    input  logic [31:0] ex_mem_store_data,
    output logic [31:0] read_data,
    output logic        mem_stall,
    output logic        access_fault,
    output logic        bus_error,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TLAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] tcnt;
    logic [1:0]    lat_off;
    logic [2:0]    lat_f3;

    logic          access;
    logic          bad;
    logic          start;
    logic          complete;
    logic          abort;
    logic [3:0]    fmt_wstrb;
    logic [31:0]   fmt_wdata;
    logic [31:0]   load_fmt;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;

    assign access = ex_mem_valid & (ex_mem_memread | ex_mem_memwrite);

    always_comb begin
        bad = 1'b1;
        case (ex_mem_funct3)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = result_ex_mem[0];
            3'b010:         bad = (result_ex_mem[1:0] != 2'b00);
            default:        bad = 1'b1;
        endcase
    end

    // Store lanes: data is replicated across the word so the strobe alone picks the bytes.
    always_comb begin
        fmt_wstrb = 4'b1111;
        fmt_wdata = ex_mem_store_data;
        case (ex_mem_funct3[1:0])
            2'b00: begin
                fmt_wstrb = 4'b0001 << result_ex_mem[1:0];
                fmt_wdata = {4{ex_mem_store_data[7:0]}};
            end
            2'b01: begin
                fmt_wstrb = result_ex_mem[1] ? 4'b1100 : 4'b0011;
                fmt_wdata = {2{ex_mem_store_data[15:0]}};
            end
            default: begin
                fmt_wstrb = 4'b1111;
                fmt_wdata = ex_mem_store_data;
            end
        endcase
    end

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (lat_off)
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lat_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        load_fmt = dmem_rdata;
        case (lat_f3)
            3'b000:  load_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  load_fmt = {24'h0, ld_byte};
            3'b001:  load_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  load_fmt = {16'h0, ld_half};
            default: load_fmt = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stall/fault are gated by reset so a live ex_mem entry cannot stall a held-in-reset core.
    always_comb begin
        state_nxt    = state;
        mem_stall    = 1'b0;
        access_fault = 1'b0;
        start        = 1'b0;
        complete     = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (bad) begin
                        access_fault = rst_n;
                    end else begin
                        start     = 1'b1;
                        mem_stall = rst_n;
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_stall = rst_n;
                if (dmem_ready) begin
                    complete  = 1'b1;
                    state_nxt = DONE;
                end else if (TIMEOUT_EN && (tcnt == TLAST)) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt       <= '0;
            lat_off    <= '0;
            lat_f3     <= '0;
            read_data  <= '0;
            bus_error  <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wstrb <= '0;
        end else begin
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= ex_mem_memwrite;
                dmem_addr  <= {result_ex_mem[31:2], 2'b00};
                dmem_wdata <= ex_mem_memwrite ? fmt_wdata : '0;
                dmem_wstrb <= ex_mem_memwrite ? fmt_wstrb : 4'b0000;
                lat_off    <= result_ex_mem[1:0];
                lat_f3     <= ex_mem_funct3;
                tcnt       <= '0;
            end
            if (state == BUSY) begin
                if (complete) begin
                    dmem_req <= 1'b0;
                    tcnt     <= '0;
                    if (!dmem_we) begin
                        read_data <= load_fmt;
                    end
                end else if (abort) begin
                    dmem_req  <= 1'b0;
                    bus_error <= 1'b1;
                    read_data <= '0;
                    tcnt      <= '0;
                end else if (TIMEOUT_EN) begin
                    tcnt <= tcnt + 1'b1;
                end
            end
            if (state == DONE) begin
                bus_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a bus responder with programmable wait
// states, expected bus fields and load results queued per transaction.
module tb_mem_access_stage;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        berr;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        ex_mem_valid;
    logic        ex_mem_memread;
    logic        ex_mem_memwrite;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] result_ex_mem;
    logic [31:0] ex_mem_store_data;
    logic [31:0] read_data;
    logic        mem_stall;
    logic        access_fault;
    logic        bus_error;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    int   n_checks = 0;
    int   n_bad    = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic prev_req = 1'b0;

    mem_access_stage #(
        .TIMEOUT_CYCLES(16),
        .TIMEOUT_EN    (1'b1)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ex_mem_valid     (ex_mem_valid),
        .ex_mem_memread   (ex_mem_memread),
        .ex_mem_memwrite  (ex_mem_memwrite),
        .ex_mem_funct3    (ex_mem_funct3),
        .result_ex_mem    (result_ex_mem),
        .ex_mem_store_data(ex_mem_store_data),
        .read_data        (read_data),
        .mem_stall        (mem_stall),
        .access_fault     (access_fault),
        .bus_error        (bus_error),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_ready       (dmem_ready),
        .dmem_rdata       (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic we, input logic [31:0] addr, input logic [3:0] wstrb,
                                input logic [31:0] wdata, input logic [31:0] rd, input logic berr);
        exp_t e;
        e.we    = we;
        e.addr  = addr;
        e.wstrb = wstrb;
        e.wdata = wdata;
        e.rd    = rd;
        e.berr  = berr;
        return e;
    endfunction

    // Bus fields are compared on the accepting beat, results on the DONE cycle.
    always @(negedge clk) begin
        if (rst_n && dmem_req && dmem_ready) begin
            if (sb.size() == 0) begin
                check("sb_empty_on_beat", sb.size(), 1);
            end else begin
                check("bus_we", dmem_we, sb[0].we);
                check("bus_addr", dmem_addr, sb[0].addr);
                check("bus_wstrb", dmem_wstrb, sb[0].wstrb);
                if (sb[0].we) check("bus_wdata", dmem_wdata, sb[0].wdata);
            end
        end
        if (rst_n && prev_req && !dmem_req) begin
            if (sb.size() == 0) begin
                check("sb_empty_on_done", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                check("read_data", read_data, mon_e.rd);
                check("bus_error", bus_error, mon_e.berr);
            end
        end
        prev_req = dmem_req;
    end

    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                       input int waits, input exp_t e, input int exp_stall);
        int stall;
        bit done;
        @(posedge clk); #1;
        ex_mem_valid      = 1'b1;
        ex_mem_memread    = rd;
        ex_mem_memwrite   = wr;
        ex_mem_funct3     = f3;
        result_ex_mem     = addr;
        ex_mem_store_data = sdata;
        dmem_ready        = 1'b0;
        dmem_rdata        = '0;
        sb.push_back(e);
        stall = 0;
        done  = 1'b0;
        @(negedge clk);
        check("idle_fault", access_fault, 0);
        check("idle_req", dmem_req, 0);
        if (mem_stall) stall++;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk); #1;
            dmem_ready        = (c == waits);
            dmem_rdata        = (c == waits) ? rdata : 32'hBAD0_BAD0;
            result_ex_mem     = addr ^ 32'h0000_0F01;
            ex_mem_funct3     = 3'b011;
            ex_mem_store_data = ~sdata;
            @(negedge clk);
            if (!dmem_req) begin
                done = 1'b1;
                check("done_stall", mem_stall, 0);
                check("done_fault", access_fault, 0);
            end else if (mem_stall) begin
                stall++;
            end
        end
        check("completed", done, 1);
        check("stall_cycles", stall, exp_stall);
        @(posedge clk); #1;
        ex_mem_valid    = 1'b0;
        ex_mem_memread  = 1'b0;
        ex_mem_memwrite = 1'b0;
        dmem_ready      = 1'b0;
        @(negedge clk);
        check("berr_clear", bus_error, 0);
        check("post_req", dmem_req, 0);
    endtask

    task automatic fault(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] exp_rd);
        @(posedge clk); #1;
        ex_mem_valid    = 1'b1;
        ex_mem_memread  = rd;
        ex_mem_memwrite = wr;
        ex_mem_funct3   = f3;
        result_ex_mem   = addr;
        dmem_ready      = 1'b0;
        @(negedge clk);
        check("fault_flag", access_fault, 1);
        check("fault_stall", mem_stall, 0);
        check("fault_req", dmem_req, 0);
        @(posedge clk); #1;
        ex_mem_valid    = 1'b0;
        ex_mem_memread  = 1'b0;
        ex_mem_memwrite = 1'b0;
        @(negedge clk);
        check("fault_req_after", dmem_req, 0);
        check("fault_rd_hold", read_data, exp_rd);
        check("fault_clear", access_fault, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n             = 1'b0;
        ex_mem_valid      = 1'b0;
        ex_mem_memread    = 1'b0;
        ex_mem_memwrite   = 1'b0;
        ex_mem_funct3     = 3'b000;
        result_ex_mem     = '0;
        ex_mem_store_data = '0;
        dmem_ready        = 1'b0;
        dmem_rdata        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_read_data", read_data, 0);
        check("rst_req", dmem_req, 0);
        check("rst_stall", mem_stall, 0);
        check("rst_fault", access_fault, 0);
        check("rst_berr", bus_error, 0);
        check("rst_wstrb", dmem_wstrb, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // loads: rd wr f3 addr sdata rdata waits / we addr wstrb wdata rd berr / stall
        run(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, mk(0, 32'h100, 4'b0000, 0, 32'hDEADBEEF, 0), 2);
        run(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 1, mk(0, 32'h100, 4'b0000, 0, 32'hFFFFFF80, 0), 3);
        run(1, 0, 3'b100, 32'h103, 0, 32'h80FF1234, 0, mk(0, 32'h100, 4'b0000, 0, 32'h00000080, 0), 2);
        run(1, 0, 3'b101, 32'h102, 0, 32'h80FF1234, 0, mk(0, 32'h100, 4'b0000, 0, 32'h000080FF, 0), 2);
        run(1, 0, 3'b001, 32'h102, 0, 32'h80FF1234, 2, mk(0, 32'h100, 4'b0000, 0, 32'hFFFF80FF, 0), 4);
        // stores leave read_data alone
        run(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, mk(1, 32'h200, 4'b1100, 32'hABCDABCD, 32'hFFFF80FF, 0), 2);
        run(0, 1, 3'b000, 32'h201, 32'h55667788, 0, 1, mk(1, 32'h200, 4'b0010, 32'h88888888, 32'hFFFF80FF, 0), 3);
        run(0, 1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 0, mk(1, 32'h300, 4'b1111, 32'hCAFEF00D, 32'hFFFF80FF, 0), 2);
        // misaligned / unsupported
        fault(1, 0, 3'b010, 32'h101, 32'hFFFF80FF);
        fault(1, 0, 3'b011, 32'h100, 32'hFFFF80FF);
        fault(1, 0, 3'b001, 32'h101, 32'hFFFF80FF);
        fault(0, 1, 3'b010, 32'h302, 32'hFFFF80FF);
        fault(1, 0, 3'b110, 32'h100, 32'hFFFF80FF);
        fault(0, 1, 3'b111, 32'h100, 32'hFFFF80FF);
        // more lanes and extensions
        run(1, 0, 3'b000, 32'h100, 0, 32'h0000007F, 0, mk(0, 32'h100, 4'b0000, 0, 32'h0000007F, 0), 2);
        run(1, 0, 3'b100, 32'h101, 0, 32'h0000AB00, 0, mk(0, 32'h100, 4'b0000, 0, 32'h000000AB, 0), 2);
        run(1, 0, 3'b001, 32'h100, 0, 32'h00008001, 0, mk(0, 32'h100, 4'b0000, 0, 32'hFFFF8001, 0), 2);
        run(1, 0, 3'b010, 32'h10C, 0, 32'h12345678, 3, mk(0, 32'h10C, 4'b0000, 0, 32'h12345678, 0), 5);
        // timeout: 16 BUSY cycles plus the IDLE cycle stalled
        run(1, 0, 3'b010, 32'h400, 0, 32'h11111111, 1000, mk(0, 32'h400, 4'b0000, 0, 32'h00000000, 1), 17);
        run(0, 1, 3'b000, 32'h203, 32'h000000A5, 0, 0, mk(1, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h00000000, 0), 2);
        run(1, 0, 3'b010, 32'h108, 0, 32'h0BADF00D, 0, mk(0, 32'h108, 4'b0000, 0, 32'h0BADF00D, 0), 2);

        // reset on the third BUSY cycle
        @(posedge clk); #1;
        ex_mem_valid    = 1'b1;
        ex_mem_memread  = 1'b1;
        ex_mem_memwrite = 1'b0;
        ex_mem_funct3   = 3'b010;
        result_ex_mem   = 32'h500;
        dmem_ready      = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("pre_rst_req", dmem_req, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_rst_req", dmem_req, 0);
        check("mid_rst_stall", mem_stall, 0);
        check("mid_rst_fault", access_fault, 0);
        check("mid_rst_rd", read_data, 0);
        check("mid_rst_berr", bus_error, 0);
        check("mid_rst_addr", dmem_addr, 0);
        check("mid_rst_wstrb", dmem_wstrb, 0);
        check("mid_rst_we", dmem_we, 0);
        @(posedge clk); #1;
        rst_n          = 1'b1;
        ex_mem_valid   = 1'b0;
        ex_mem_memread = 1'b0;
        @(negedge clk);
        check("post_rst_req", dmem_req, 0);
        check("post_rst_stall", mem_stall, 0);
        run(1, 0, 3'b010, 32'h104, 0, 32'h13579BDF, 0, mk(0, 32'h104, 4'b0000, 0, 32'h13579BDF, 0), 2);

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
